rf_wport_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order WB stage and the long-latency

---
 rtl/cpu_pkg.sv | 12 +
 rtl/rf_wport_arbiter_if.sv | 43 ++++
 rtl/rf_wport_arbiter_fifo.sv | 47 ++++
 rtl/rf_wport_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wport_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for register-file write traffic.
// Address/data widths and the RF write bundle.
package cpu_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] waddr;
    logic [RF_DATA_W-1:0] wdata;
  } rf_wr_t;
endpackage

// File: rtl/rf_wport_arbiter_if.sv
// WB request, LU result, issue tracking and RF write bundle.
// master drives requests; slave is the arbiter.
interface rf_wport_arbiter_if;
  import cpu_pkg::*;

  logic                 ws_req_valid;
  logic                 ws_req_we;
  logic [RF_ADDR_W-1:0] ws_req_waddr;
  logic [RF_DATA_W-1:0] ws_req_wdata;
  logic                 ws_ready_go;
  logic                 lu_valid;
  logic                 lu_ready;
  logic [RF_ADDR_W-1:0] lu_waddr;
  logic [RF_DATA_W-1:0] lu_wdata;
  logic                 issue_valid;
  logic [RF_ADDR_W-1:0] issue_waddr;
  logic [31:0]          lu_busy_mask;
  logic                 rf_we;
  logic [RF_ADDR_W-1:0] rf_waddr;
  logic [RF_DATA_W-1:0] rf_wdata;

  modport master (
    output ws_req_valid, ws_req_we,
    output ws_req_waddr, ws_req_wdata,
    input  ws_ready_go,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready,
    output issue_valid, issue_waddr,
    input  lu_busy_mask,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  ws_req_valid, ws_req_we,
    input  ws_req_waddr, ws_req_wdata,
    output ws_ready_go,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready,
    input  issue_valid, issue_waddr,
    output lu_busy_mask,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_wport_arbiter_fifo.sv
// Synchronous FIFO buffering long-latency results.
// Depth must be a power of two so pointers wrap naturally.
module rf_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/rf_wport_arbiter.sv
// RF write-port arbiter: WB priority, bounded LU fairness, busy mask.
// RF_ARB_PERF_EN adds perf_ws_stall_cnt (WB stall cycle counter).
module rf_wport_arbiter
  import cpu_pkg::*;
#(
  parameter int LU_FIFO_DEPTH = 2,
  parameter int MAX_WB_WINS   = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  rf_wport_arbiter_if.slave    bus
`ifdef RF_ARB_PERF_EN
  ,
  output logic [31:0]          perf_ws_stall_cnt
`endif
);
  localparam int WW = $clog2(MAX_WB_WINS + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WB_WINS);

  rf_wr_t      lu_in;
  rf_wr_t      lu_head;
  rf_wr_t      wr;
  logic        full;
  logic        empty;
  logic        wb_want;
  logic        lu_want;
  logic        wb_gnt;
  logic        lu_gnt;
  logic [WW-1:0] wins;
  logic [31:0] mask;
  logic [31:0] mask_nxt;

  assign lu_in = '{we:    bus.lu_waddr != '0,
                   waddr: bus.lu_waddr,
                   wdata: bus.lu_wdata};

  rf_arb_fifo #(
    .DEPTH (LU_FIFO_DEPTH),
    .W     ($bits(rf_wr_t))
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (bus.lu_valid && bus.lu_ready),
    .pop    (lu_gnt),
    .din    (lu_in),
    .dout   (lu_head),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    wb_want = resetn && bus.ws_req_valid
                     && bus.ws_req_we;
    lu_want = resetn && !empty;
    lu_gnt  = lu_want && (!wb_want || wins == WMAX);
    wb_gnt  = wb_want && !lu_gnt;
    wr      = '0;
    if (lu_gnt) begin
      wr = lu_head;
    end else if (wb_gnt) begin
      wr = '{we:    bus.ws_req_waddr != '0,
             waddr: bus.ws_req_waddr,
             wdata: bus.ws_req_wdata};
    end
  end

  assign bus.rf_we        = wr.we;
  assign bus.rf_waddr     = wr.waddr;
  assign bus.rf_wdata     = wr.wdata;
  assign bus.ws_ready_go  = !(wb_want && lu_gnt);
  assign bus.lu_ready     = resetn && !full;
  assign bus.lu_busy_mask = resetn ? mask : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wins <= '0;
    end else if (lu_gnt || !lu_want) begin
      wins <= '0;
    end else if (wb_gnt && wins != WMAX) begin
      wins <= wins + 1'b1;
    end
  end

  // A new issue to the same reg outranks the retiring write.
  always_comb begin
    mask_nxt = mask;
    if (lu_gnt) mask_nxt[lu_head.waddr] = 1'b0;
    if (bus.issue_valid)
      mask_nxt[bus.issue_waddr] = 1'b1;
    mask_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) mask <= '0;
    else         mask <= mask_nxt;
  end

`ifdef RF_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      perf_ws_stall_cnt <= '0;
    else if (!bus.ws_ready_go)
      perf_ws_stall_cnt <= perf_ws_stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with an RF write scoreboard.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_rf_wport_arbiter;
  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  logic [36:0] sb[$];
`ifdef RF_ARB_PERF_EN
  logic [31:0] perf;
  logic [31:0] p0;
`endif

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef RF_ARB_PERF_EN
    ,
    .perf_ws_stall_cnt (perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic negc();
    logic [36:0] e;
    @(negedge clk);
    if (bus.rf_we === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rf_write",
            64'({bus.rf_waddr, bus.rf_wdata}),
            64'(e));
      end
    end
  endtask

  task automatic posc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a,
                    input logic [31:0] d);
    bus.ws_req_valid = 1'b1;
    bus.ws_req_we    = 1'b1;
    bus.ws_req_waddr = a;
    bus.ws_req_wdata = d;
  endtask

  task automatic wb_off();
    bus.ws_req_valid = 1'b0;
    bus.ws_req_we    = 1'b0;
  endtask

  task automatic lu(input logic [4:0] a,
                    input logic [31:0] d);
    bus.lu_valid = 1'b1;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.issue_valid = 1'b1;
    bus.issue_waddr = a;
  endtask

  initial begin
    int k;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    wb_off();
    bus.ws_req_waddr = '0;
    bus.ws_req_wdata = '0;
    bus.lu_valid     = 1'b0;
    bus.lu_waddr     = '0;
    bus.lu_wdata     = '0;
    bus.issue_valid  = 1'b0;
    bus.issue_waddr  = '0;

    // reset state
    negc();
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_ready_go", 64'(bus.ws_ready_go), 64'd1);
    chk("rst_lu_ready", 64'(bus.lu_ready), 64'd0);
    chk("rst_mask", 64'(bus.lu_busy_mask), 64'd0);
    posc();
    resetn = 1'b1;

    // 1: issue r5, LU returns r5
    issue(5'd5);
    negc(); posc();
    bus.issue_valid = 1'b0;
    lu(5'd5, 32'h1234);
    negc();
    chk("s1_lu_ready", 64'(bus.lu_ready), 64'd1);
    chk("s1_mask_set", 64'(bus.lu_busy_mask), 64'h20);
    posc();
    bus.lu_valid = 1'b0;
    sb.push_back({5'd5, 32'h1234});
    negc();
    chk("s1_mask_pend", 64'(bus.lu_busy_mask), 64'h20);
    posc();
    negc();
    chk("s1_mask_clr", 64'(bus.lu_busy_mask), 64'd0);
    posc();

    // 2: WB every cycle, one LU entry waits 4 wins
`ifdef RF_ARB_PERF_EN
    p0 = perf;
`endif
    k = 1;
    for (int c = 0; c < 8; c++) begin
      wb(5'(k), 32'h100 + 32'(k));
      if (c == 0) lu(5'd9, 32'hAAAA);
      else bus.lu_valid = 1'b0;
      if (c == 5) sb.push_back({5'd9, 32'hAAAA});
      else sb.push_back({5'(k), 32'h100 + 32'(k)});
      negc();
      chk($sformatf("s2_ready_go_c%0d", c),
          64'(bus.ws_ready_go), 64'(c != 5));
      if (c == 0)
        chk("s2_lu_ready", 64'(bus.lu_ready), 64'd1);
      posc();
      if (c != 5) k++;
    end
    wb_off();
`ifdef RF_ARB_PERF_EN
    chk("s2_perf", 64'(perf - p0), 64'd1);
`endif
    negc(); posc();

    // 3: three LU results back-to-back, FIFO fills
    k = 0;
    for (int c = 0; c < 9; c++) begin
      if (c <= 6) wb(5'(20 + k), 32'h300 + 32'(k));
      else wb_off();
      case (c)
        0:       lu(5'd14, 32'hA0);
        1:       lu(5'd15, 32'hB0);
        2, 3, 4,
        5, 6:    lu(5'd16, 32'hC0);
        default: bus.lu_valid = 1'b0;
      endcase
      case (c)
        5:       sb.push_back({5'd14, 32'hA0});
        7:       sb.push_back({5'd15, 32'hB0});
        8:       sb.push_back({5'd16, 32'hC0});
        default: sb.push_back({5'(20 + k),
                               32'h300 + 32'(k)});
      endcase
      negc();
      chk($sformatf("s3_ready_go_c%0d", c),
          64'(bus.ws_ready_go), 64'(c != 5));
      chk($sformatf("s3_lu_ready_c%0d", c),
          64'(bus.lu_ready),
          64'(c < 2 || c == 6 || c == 8));
      posc();
      if (c <= 6 && c != 5) k++;
    end
    bus.lu_valid = 1'b0;

    // 4: LU result to r0 is dropped but popped
    lu(5'd0, 32'hDEAD);
    negc();
    chk("s4_lu_ready0", 64'(bus.lu_ready), 64'd1);
    posc();
    lu(5'd10, 32'hE0);
    negc();
    chk("s4_zero_we", 64'(bus.rf_we), 64'd0);
    chk("s4_ready_go", 64'(bus.ws_ready_go), 64'd1);
    chk("s4_lu_ready1", 64'(bus.lu_ready), 64'd1);
    posc();
    bus.lu_valid = 1'b0;
    sb.push_back({5'd10, 32'hE0});
    negc();
    chk("s4_lu_ready2", 64'(bus.lu_ready), 64'd1);
    posc();

    // 5: set beats clear on same reg
    issue(5'd7);
    negc(); posc();
    bus.issue_valid = 1'b0;
    lu(5'd7, 32'h77);
    negc();
    chk("s5_mask_pre", 64'(bus.lu_busy_mask), 64'h80);
    posc();
    bus.lu_valid = 1'b0;
    issue(5'd7);
    sb.push_back({5'd7, 32'h77});
    negc(); posc();
    bus.issue_valid = 1'b0;
    negc();
    chk("s5_set_wins", 64'(bus.lu_busy_mask), 64'h80);
    posc();

    // 5b: reset with two buffered LU entries
    wb(5'd1, 32'h501);
    lu(5'd12, 32'hC12);
    sb.push_back({5'd1, 32'h501});
    negc(); posc();
    wb(5'd2, 32'h502);
    lu(5'd13, 32'hC13);
    sb.push_back({5'd2, 32'h502});
    negc();
    chk("s5_lu_ready", 64'(bus.lu_ready), 64'd1);
    posc();
    bus.lu_valid = 1'b0;
    resetn = 1'b0;
    negc();
    chk("s5_rst_we", 64'(bus.rf_we), 64'd0);
    chk("s5_rst_go", 64'(bus.ws_ready_go), 64'd1);
    chk("s5_rst_lu_ready", 64'(bus.lu_ready), 64'd0);
    chk("s5_rst_mask", 64'(bus.lu_busy_mask), 64'd0);
    posc();
    resetn = 1'b1;
    wb_off();
    negc();
    chk("s5_post_we", 64'(bus.rf_we), 64'd0);
    chk("s5_post_mask", 64'(bus.lu_busy_mask), 64'd0);
    chk("s5_post_lu_ready", 64'(bus.lu_ready), 64'd1);
    posc();
    negc();
    chk("s5_post_we2", 64'(bus.rf_we), 64'd0);
    posc();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
